// File: rtl/aes_pkg.sv
// Shared types and helpers for the iterative AES key-schedule engine.
package aes_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] rkey_t;

  // GF(2^8) doubling modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic int unsigned nr_from_nk(input int unsigned nk);
    return nk + 6;
  endfunction

  function automatic bit key_bits_legal(input int unsigned kb);
    return (kb == 128) || (kb == 192) || (kb == 256);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] z);
    logic [7:0] p;
    logic [7:0] s;
    p = '0;
    s = x;
    for (int unsigned k = 0; k < 8; k++) begin
      if (z[k]) p = p ^ s;
      s = xtime(s);
    end
    return p;
  endfunction

  logic [7:0] sq;
  logic [7:0] inv;

  // inverse = a^254 = product of a^(2^k) for k=1..7; maps 0 to 0
  always_comb begin
    sq  = a;
    inv = 8'h01;
    for (int unsigned k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
            ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/aes_subword.sv
// SubWord: four parallel S-box lookups across a 32-bit word.
module aes_subword
  import aes_pkg::*;
(
  input  word_t word,
  output word_t sub
);

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .a (word[8*g +: 8]),
      .y (sub[8*g +: 8])
    );
  end

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES key schedule: one schedule word per clock, round keys
// delivered over a valid/ready handshake.
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int unsigned KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [KEY_BITS-1:0] key_in,
  output logic                busy,
  output logic                rk_valid,
  input  logic                rk_ready,
  output logic [3:0]          rk_round,
  output logic [127:0]        rk_data,
  output logic                done
);

  localparam int unsigned NK    = KEY_BITS / 32;
  localparam int unsigned NR    = nr_from_nk(NK);
  localparam int unsigned TOTAL = 4 * (NR + 1);
  localparam int unsigned IW    = $clog2(NK);

  if (!key_bits_legal(KEY_BITS)) begin : g_bad_key_bits
    $error("aes_key_expand: KEY_BITS must be 128, 192 or 256");
  end

  typedef enum logic [1:0] {IDLE, EXPAND, FIN} state_t;

  state_t        state;
  word_t         window [NK];
  logic [5:0]    idx;
  logic [IW-1:0] wrap;
  logic [7:0]    rcon;
  word_t         col [3];
  logic [3:0]    next_round;

  word_t prev;
  word_t rot_in;
  word_t sub_out;
  word_t temp;
  word_t word_new;
  logic  past_key;
  logic  wrap_zero;
  logic  last_col;
  logic  stall;
  logic  gen;
  logic  accept;

  assign prev      = window[NK-1];
  assign past_key  = idx >= 6'(NK);
  assign wrap_zero = wrap == '0;
  assign last_col  = idx[1:0] == 2'b11;
  assign accept    = rk_valid && rk_ready;
  assign stall     = last_col && rk_valid && !rk_ready;
  assign gen       = (state == EXPAND) && (idx < 6'(TOTAL)) && !stall;
  assign rot_in    = wrap_zero ? {prev[23:0], prev[31:24]} : prev;

  aes_subword u_subword (
    .word (rot_in),
    .sub  (sub_out)
  );

  // Before NK words the window still holds the raw key, read in place.
  always_comb begin
    temp = prev;
    if (wrap_zero)
      temp = sub_out ^ {rcon, 24'h0};
    else if (NK == 8 && 32'(wrap) == 32'd4)
      temp = sub_out;
    word_new = past_key ? (window[0] ^ temp) : window[wrap];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      for (int unsigned j = 0; j < NK; j++) window[j] <= '0;
      for (int unsigned j = 0; j < 3; j++) col[j] <= '0;
      idx        <= '0;
      wrap       <= '0;
      rcon       <= '0;
      next_round <= '0;
      busy       <= 1'b0;
      rk_valid   <= 1'b0;
      rk_round   <= '0;
      rk_data    <= '0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            for (int unsigned j = 0; j < NK; j++)
              window[j] <= key_in[KEY_BITS-1-32*j -: 32];
            idx        <= '0;
            wrap       <= '0;
            rcon       <= 8'h01;
            next_round <= '0;
            busy       <= 1'b1;
            state      <= EXPAND;
          end
        end

        EXPAND: begin
          if (accept) rk_valid <= 1'b0;
          if (gen) begin
            if (past_key) begin
              for (int unsigned j = 0; j + 1 < NK; j++) window[j] <= window[j+1];
              window[NK-1] <= word_new;
              if (wrap_zero) rcon <= xtime(rcon);
            end
            wrap <= (wrap == IW'(NK - 1)) ? '0 : wrap + 1'b1;
            idx  <= idx + 1'b1;
            // 4th word bypasses the collector; a new key overrides the clear above
            if (last_col) begin
              rk_data    <= {col[0], col[1], col[2], word_new};
              rk_round   <= next_round;
              next_round <= next_round + 1'b1;
              rk_valid   <= 1'b1;
            end else begin
              col[idx[1:0]] <= word_new;
            end
          end
          if (idx == 6'(TOTAL) && accept) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end
        end

        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand at all three key lengths.
module tb_aes_key_expand;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic         start_a, ready_a, busy_a, valid_a, done_a;
  logic [127:0] key_a, data_a;
  logic [3:0]   round_a;
  logic         start_b, ready_b, busy_b, valid_b, done_b;
  logic [191:0] key_b;
  logic [127:0] data_b;
  logic [3:0]   round_b;
  logic         start_c, ready_c, busy_c, valid_c, done_c;
  logic [255:0] key_c;
  logic [127:0] data_c;
  logic [3:0]   round_c;

  aes_key_expand #(.KEY_BITS(128)) u_dut128 (
    .clk(clk), .rst_n(rst_n), .start(start_a), .key_in(key_a), .busy(busy_a),
    .rk_valid(valid_a), .rk_ready(ready_a), .rk_round(round_a), .rk_data(data_a), .done(done_a));
  aes_key_expand #(.KEY_BITS(192)) u_dut192 (
    .clk(clk), .rst_n(rst_n), .start(start_b), .key_in(key_b), .busy(busy_b),
    .rk_valid(valid_b), .rk_ready(ready_b), .rk_round(round_b), .rk_data(data_b), .done(done_b));
  aes_key_expand #(.KEY_BITS(256)) u_dut256 (
    .clk(clk), .rst_n(rst_n), .start(start_c), .key_in(key_c), .busy(busy_c),
    .rk_valid(valid_c), .rk_ready(ready_c), .rk_round(round_c), .rk_data(data_c), .done(done_c));

  localparam logic [127:0] K128    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K128_R1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K128_RA = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [191:0] K192    = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [127:0] K192_R1 = 128'h62f8ead2522c6b7bfe0c91f72402f5a5;
  localparam logic [127:0] K192_RC = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [255:0] K256    = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] K256_R1 = 128'h1f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] K256_RE = 128'hfe4890d1e6188d0b046df344706c631e;

  logic [127:0] sbox_rows [16] = '{
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  typedef logic [127:0] rks_t [15];

  function automatic logic [7:0] sb(input logic [7:0] b);
    logic [127:0] row;
    row = sbox_rows[b[7:4]];
    return row[127 - 8*int'(b[3:0]) -: 8];
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
  endfunction

  // Textbook key expansion over a flat word array.
  function automatic rks_t expand(input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc [10];
    rks_t        r;
    rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    for (int i = 0; i < nk; i++) w[i] = key[32*(nk-i)-1 -: 32];
    for (int i = nk; i < 4*(nk+7); i++) begin
      t = w[i-1];
      if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rc[i/nk-1], 24'h0};
      else if (nk == 8 && i % nk == 4) t = subw(t);
      w[i] = w[i-nk] ^ t;
    end
    for (int q = 0; q < 15; q++)
      r[q] = (q <= nk + 6) ? {w[4*q], w[4*q+1], w[4*q+2], w[4*q+3]} : '0;
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  int           exp_idx [3];
  logic         p_busy [3], p_start [3], p_done [3], p_valid [3], p_ready [3];
  logic [3:0]   p_round [3];
  logic [127:0] p_data [3];
  logic [255:0] p_key [3];
  logic [127:0] keys [3][15];
  logic         p_rst = 1'b0;

  task automatic check_inst(input int k, input int nk, input logic start, input logic [255:0] key,
                            input logic busy, input logic valid, input logic ready,
                            input logic [3:0] round, input logic [127:0] data, input logic done);
    int    nr;
    rks_t  tmp;
    string t;
    nr = nk + 6;
    t  = $sformatf("k%0d", nk * 32);
    if (!rst_n) begin
      chk({t, "_rst_busy"},  128'(busy), '0);
      chk({t, "_rst_valid"}, 128'(valid), '0);
      chk({t, "_rst_done"},  128'(done), '0);
      chk({t, "_rst_round"}, 128'(round), '0);
      chk({t, "_rst_data"},  data, '0);
      exp_idx[k] = 0;
    end else begin
      if (p_rst && !p_busy[k]) begin
        chk({t, "_accept"}, 128'(busy), 128'(p_start[k] && !p_done[k]));
        if (busy) begin
          tmp = expand(p_key[k], nk);
          for (int j = 0; j < 15; j++) keys[k][j] = tmp[j];
          exp_idx[k] = 0;
        end
      end
      if (p_busy[k] && !busy) begin
        chk({t, "_end_done"}, 128'(done), 128'(1));
        chk({t, "_end_count"}, 128'(exp_idx[k]), 128'(nr + 1));
      end
      if (done) chk({t, "_done_pulse"}, 128'(p_done[k]), '0);
      if (p_valid[k] && !p_ready[k]) begin
        chk({t, "_hold_valid"}, 128'(valid), 128'(1));
        chk({t, "_hold_round"}, 128'(round), 128'(p_round[k]));
        chk({t, "_hold_data"}, data, p_data[k]);
      end
      if (valid) begin
        if (exp_idx[k] > nr) begin
          chk({t, "_extra_key"}, 128'(exp_idx[k]), 128'(nr));
        end else begin
          chk({t, "_round"}, 128'(round), 128'(exp_idx[k]));
          chk($sformatf("%s_data_r%0d", t, exp_idx[k]), data, keys[k][exp_idx[k]]);
          if (ready) exp_idx[k]++;
        end
      end
    end
    p_busy[k] = busy;  p_start[k] = start; p_done[k] = done;
    p_valid[k] = valid; p_ready[k] = ready; p_round[k] = round;
    p_data[k] = data;  p_key[k] = key;
  endtask

  always @(negedge clk) begin
    check_inst(0, 4, start_a, {128'h0, key_a}, busy_a, valid_a, ready_a, round_a, data_a, done_a);
    check_inst(1, 6, start_b, {64'h0, key_b},  busy_b, valid_b, ready_b, round_b, data_b, done_b);
    check_inst(2, 8, start_c, key_c,           busy_c, valid_c, ready_c, round_c, data_c, done_c);
    p_rst = rst_n;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic start_a_run(input logic [127:0] key);
    key_a   = key;
    start_a = 1'b1;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (busy_a) break;
    end
    start_a = 1'b0;
    chk("k128_start_taken", 128'(busy_a), 128'(1));
  endtask

  task automatic first_key_latency(input logic [127:0] key);
    for (int n = 1; n <= 4; n++) begin
      tick();
      chk($sformatf("k128_latency_e%0d", n), 128'(valid_a), 128'(n == 4));
    end
    chk("k128_r0_literal", data_a, key);
  endtask

  task automatic finish_a(input bit rnd);
    for (int n = 0; n < 1500; n++) begin
      ready_a = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
      if (rnd && $urandom_range(0, 7) == 0) key_a = rnd128();
      tick();
      if (done_a) break;
    end
    chk("k128_run_done", 128'(done_a), 128'(1));
    ready_a = 1'b1;
  endtask

  rks_t m;
  int   seen [3];
  int   gap;

  initial begin
    start_a = 0; start_b = 0; start_c = 0;
    key_a = '0; key_b = '0; key_c = '0;
    ready_a = 1; ready_b = 1; ready_c = 1;
    #3 rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    m = expand({128'h0, K128}, 4);
    chk("model_k128_r0", m[0], K128);
    chk("model_k128_r1", m[1], K128_R1);
    chk("model_k128_r10", m[10], K128_RA);
    m = expand({64'h0, K192}, 6);
    chk("model_k192_r1", m[1], K192_R1);
    chk("model_k192_r12", m[12], K192_RC);
    m = expand(K256, 8);
    chk("model_k256_r1", m[1], K256_R1);
    chk("model_k256_r14", m[14], K256_RE);

    // FIPS-197 vectors, all three widths, consumer always ready
    key_a = K128; key_b = K192; key_c = K256;
    start_a = 1; start_b = 1; start_c = 1;
    tick();
    start_a = 0; start_b = 0; start_c = 0;
    chk("k128_busy_e0", 128'(busy_a), 128'(1));
    first_key_latency(K128);
    for (int n = 5; n <= 44; n++) begin
      tick();
      if (n == 8) begin
        chk("k128_r1_e8", data_a, K128_R1);
        chk("k192_r1_e8", data_b, K192_R1);
        chk("k256_r1_e8", data_c, K256_R1);
      end
      if (n == 43) chk("k128_no_early_r10", 128'(valid_a), '0);
    end
    chk("k128_r10_e44_valid", 128'(valid_a), 128'(1));
    chk("k128_r10_e44_round", 128'(round_a), 128'(10));
    chk("k128_r10_e44_data", data_a, K128_RA);
    seen = '{0, 0, 0};
    for (int n = 0; n < 40; n++) begin
      tick();
      if (done_a) seen[0]++;
      if (done_b) seen[1]++;
      if (done_c) seen[2]++;
    end
    chk("k128_done_once", 128'(seen[0]), 128'(1));
    chk("k192_done_once", 128'(seen[1]), 128'(1));
    chk("k256_done_once", 128'(seen[2]), 128'(1));

    // random backpressure, random keys
    for (int r = 0; r < 3; r++) begin
      start_a_run(r == 0 ? K128 : rnd128());
      finish_a(1'b1);
    end
    key_b = {rnd128(), $urandom(), $urandom()};
    key_c = {rnd128(), rnd128()};
    start_b = 1; start_c = 1;
    tick();
    start_b = 0; start_c = 0;
    seen = '{0, 0, 0};
    for (int n = 0; n < 2000 && (seen[1] == 0 || seen[2] == 0); n++) begin
      ready_b = $urandom_range(0, 9) < 3;
      ready_c = $urandom_range(0, 9) < 3;
      tick();
      if (done_b) seen[1]++;
      if (done_c) seen[2]++;
    end
    chk("k192_rand_done", 128'(seen[1]), 128'(1));
    chk("k256_rand_done", 128'(seen[2]), 128'(1));
    ready_b = 1; ready_c = 1;
    repeat (3) tick();

    // ignored restart, then reset abort and a fresh run
    start_a_run(K128);
    ready_a = 1;
    for (int n = 1; n < 10; n++) tick();
    key_a = 128'h000102030405060708090a0b0c0d0e0f;
    start_a = 1;
    tick();
    start_a = 0;
    for (int n = 11; n < 20; n++) tick();
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 128'(busy_a), '0);
    chk("abort_valid", 128'(valid_a), '0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    start_a_run(128'h000102030405060708090a0b0c0d0e0f);
    first_key_latency(128'h000102030405060708090a0b0c0d0e0f);
    finish_a(1'b0);
    tick();

    // back-to-back: start held through done
    key_a   = rnd128();
    start_a = 1;
    for (int n = 0; n < 10 && !busy_a; n++) tick();
    key_a = rnd128();
    for (int n = 0; n < 100; n++) begin
      tick();
      if (done_a) break;
    end
    chk("b2b_first_done", 128'(done_a), 128'(1));
    tick();
    chk("b2b_done_one_cycle", 128'(done_a), '0);
    gap = 0;
    for (int n = 0; n < 20; n++) begin
      tick();
      gap++;
      if (valid_a) break;
    end
    chk("b2b_gap", 128'(gap), 128'(5));
    chk("b2b_r0_new_key", data_a, key_a);
    start_a = 0;
    finish_a(1'b0);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
Iterative AES key-schedule engine that replaces the single-round combinational key generator. It accepts a cipher key, generates one 32-bit schedule word per clock, and delivers each 128-bit round key with its round index over a valid/ready handshake. The key length is a parameter (128, 192 or 256 bits). The block sits between the key register and the round datapath, or a round-key store.

Parameters:
KEY_BITS, 128, cipher key length; legal values 128/192/256; any other value is an elaboration error.
NK, KEY_BITS/32, derived localparam; key length in words (4/6/8).
NR, NK+6, derived localparam; number of rounds (10/12/14).

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  begin expansion; accepted only when busy=0.
key_in  input  KEY_BITS  cipher key; FIPS-197 ordering, w0 = key_in[KEY_BITS-1 -: 32]; sampled only on the start-accept edge.
busy  output  1  high from the start-accept edge until done.
rk_valid  output  1  rk_data/rk_round hold a round key.
rk_ready  input  1  consumer accepts the key when rk_valid && rk_ready.
rk_round  output  4  round index of rk_data, 0..NR.
rk_data  output  128  round key {w[4r],w[4r+1],w[4r+2],w[4r+3]}; w[4r] is in [127:96].
done  output  1  one-cycle pulse after the round-NR key is accepted.

Behaviour:
- Reset: busy=0, rk_valid=0, rk_round=0, rk_data=0, done=0. The state machine returns to IDLE and the window, collector and counters clear. Reset mid-expansion aborts the run; no partial key is presented afterwards.
- States:
  - IDLE: start → EXPAND. The start edge loads the NK-word window with key_in, clears word index i, sets rcon=0x01 and busy=1.
  - EXPAND: emits word w[i] each cycle unless stalled. Once i reaches 4(NR+1) and the last key is accepted, the block enters FIN.
  - FIN: done=1 for one cycle, busy=0 → IDLE.
- Word generation:
  - i<NK: w[i] = window word i.
  - i>=NK: temp = w[i-1].
    - If i mod NK==0: temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}.
    - Else if NK==8 and i mod NK==4: temp = SubWord(temp).
    - w[i] = w[i-NK] ^ temp. The result shifts into the window and w[i-NK] is dropped.
  - RotWord is a left rotate by one byte. SubWord is 4 parallel sbox lookups.
  - rcon advances by xtime (GF(2^8) doubling) after each use, giving 01,02,04,08,10,20,40,80,1b,36.
  - i mod NK is tracked by a wrap counter; no dividers.
- Collector: holds 3 words. The 4th word of a round, together with the 3 collected words, loads directly into the output register in the same edge.
  - rk_round increments per loaded key.
  - rk_valid rises that edge.
- Latency: start accepted at edge E0; w0..w3 are written at E1..E4; rk_valid is high after E4.
  - With rk_ready held at 1, round r is valid after edge E(4r+4), so one key per 4 cycles with no bubbles.
  - Total run is 4(NR+1) cycles plus FIN: 44/52/60 word cycles.
- Backpressure: generation stalls (i, window, collector and rcon frozen) only when the 4th word of a round is due while rk_valid=1 and rk_ready=0.
  - While stalled, rk_data and rk_round stay stable.
  - When a handshake and a 4th-word load occur on the same edge, the new key replaces the old one; rk_valid stays 1.
- Handshake: rk_valid stays high until accepted. After the round-NR acceptance rk_valid=0 and no further keys appear.
- start while busy=1 is ignored, and key_in changes while busy have no effect.
- done and a new start on the same cycle: start is accepted on the following IDLE cycle, not in FIN.

Decomposition:
- Package aes_pkg holds:
  - the word type (32 bits) and round-key type (128 bits);
  - the xtime function;
  - the NR-from-NK function;
  - the legal KEY_BITS check.
- Sub-module: aes_subword. It contains 4 instances of the existing sbox module and maps a 32-bit word to a 32-bit word. It is instantiated once.

Test Plan:
- KEY_BITS=128, key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 → round 0 = the key after E4; round 1 = a0fafe1788542cb123a339392a6c7605 after E8; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 after E44; done pulses once.
- KEY_BITS=192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b → round 1 = 62f8ead2522c6b7bfe0c91f72402f5a5; round 12 = e98ba06f448c773c8ecc720401002202; 13 keys total.
- KEY_BITS=256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 → round 1 = 1f352c073b6108d72d9810a30914dff4; round 14 = fe4890d1e6188d0b046df344706c631e.
- 128-bit key with random rk_ready (about 30% high) → the same 11 keys in order; rk_data and rk_round stable while rk_valid && !rk_ready; no key skipped or duplicated.
- start pulsed at cycle 10 of a run with a different key_in → ignored; output matches the first key. rst_n asserted at cycle 20 → rk_valid=0 and busy=0 immediately. A new start then yields round 0 of the new key after 4 cycles.
- Back-to-back runs: start held high through done → second run begins one cycle after FIN; round 0 of the second run appears 5 cycles after the done pulse.
